// File: rtl/ising_core_reg_slv.sv
// ising_core_reg_slv
// -----------------------------------------------------------------------------
// Register slave that controls one Ising annealing engine through a
// zero-wait-state register bus.
//
// Register window: 8 words starting at BaseAddr.
//   0x00 CTRL        bit0 START (pulse), bit1 SOFT_RST (pulse), bit2 IRQ_EN (RW)
//   0x04 STATUS      bit0 BUSY (RO), bit1 DONE (W1C), bit2 TIMEOUT (W1C)
//   0x08 CFG_CYCLES  RW [CntW-1:0]
//   0x0C TIMEOUT_LIM RW [CntW-1:0], 0 disables the timeout
//   0x10 ENERGY_LO   RO, low word of the sign-extended engine energy
//   0x14 ENERGY_HI   RO, high word of the sign-extended engine energy
//   0x18 RUN_CNT     RO [CntW-1:0], completed runs, wraps
//   0x1C SCRATCH     RW 32
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   reg_valid_i/reg_write_i    request valid, 1 = write
//   reg_addr_i                 byte address
//   reg_wdata_i/reg_wstrb_i    write data and byte enables
//   reg_ready_o                mirrors reg_valid_i (no wait states)
//   reg_rdata_o/reg_error_o    combinational read data and access error
//   start_o/abort_o            one-cycle engine start / abort pulses
//   cfg_cycles_o               annealing cycle count for the engine
//   done_i/energy_i            engine completion pulse and signed result
//   irq_o                      level interrupt, IRQ_EN & (DONE | TIMEOUT)
// -----------------------------------------------------------------------------
module ising_core_reg_slv #(
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          EnergyW   = 32,
  parameter int unsigned          CntW      = 16,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic                   start_o,
  output logic                   abort_o,
  output logic [CntW-1:0]        cfg_cycles_o,
  input  logic                   done_i,
  input  logic [EnergyW-1:0]     energy_i,
  output logic                   irq_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] W_CTRL    = 3'd0;
  localparam logic [2:0] W_STATUS  = 3'd1;
  localparam logic [2:0] W_CFG     = 3'd2;
  localparam logic [2:0] W_LIM     = 3'd3;
  localparam logic [2:0] W_ENE_LO  = 3'd4;
  localparam logic [2:0] W_ENE_HI  = 3'd5;
  localparam logic [2:0] W_RUN_CNT = 3'd6;
  localparam logic [2:0] W_SCRATCH = 3'd7;

  // State
  state_e                 state_reg,       state_next;
  logic                   irq_en_reg,      irq_en_next;
  logic                   done_reg,        done_next;
  logic                   timeout_reg,     timeout_next;
  logic [CntW-1:0]        cfg_cycles_reg,  cfg_cycles_next;
  logic [CntW-1:0]        timeout_lim_reg, timeout_lim_next;
  logic [63:0]            energy_reg,      energy_next;
  logic [CntW-1:0]        run_cnt_reg,     run_cnt_next;
  logic [DataWidth-1:0]   scratch_reg,     scratch_next;
  logic [CntW-1:0]        cyc_cnt_reg,     cyc_cnt_next;
  logic                   start_reg,       start_next;
  logic                   abort_reg,       abort_next;

  // Address decode. Subtracting the base first makes the window check a
  // single unsigned compare; addresses below the base wrap to huge offsets.
  logic [AddrWidth-1:0]   offset;
  logic                   in_window;
  logic                   aligned;
  logic [2:0]             word_idx;
  logic                   ro_write;
  logic                   access_err;
  logic                   wr_ok;
  logic                   ctrl_b0_wr;
  logic                   soft_rst;
  logic [DataWidth-1:0]   wmask;
  logic [63:0]            energy_ext;

  assign offset     = reg_addr_i - BaseAddr;
  assign in_window  = (offset < AddrWidth'(32));
  assign aligned    = (offset[1:0] == 2'b00);
  assign word_idx   = offset[4:2];
  assign ro_write   = reg_write_i &&
                      ((word_idx == W_ENE_LO) || (word_idx == W_ENE_HI) ||
                       (word_idx == W_RUN_CNT));
  assign access_err = !in_window || !aligned || ro_write;
  assign wr_ok      = reg_valid_i && reg_write_i && !access_err;

  // Pulse and W1C bits live in byte 0 and only act when that lane is enabled.
  assign ctrl_b0_wr = wr_ok && (word_idx == W_CTRL) && reg_wstrb_i[0];
  assign soft_rst   = ctrl_b0_wr && reg_wdata_i[1];

  // Per-byte write mask for the RW fields.
  generate
    for (genvar gi = 0; gi < DataWidth / 8; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{reg_wstrb_i[gi]}};
    end
  endgenerate

  // Signed energy widened to the 64-bit ENERGY_HI:LO pair.
  assign energy_ext = 64'($signed(energy_i));

  function automatic logic [DataWidth-1:0] merge_bytes(
    input logic [DataWidth-1:0] old_val,
    input logic [DataWidth-1:0] new_val,
    input logic [DataWidth-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Next-state logic. Order matters: bus writes first, engine events second
  // so a flag being set beats a W1C in the same cycle, soft reset last so it
  // overrides everything including a START in the same write.
  always_comb begin
    state_next       = state_reg;
    irq_en_next      = irq_en_reg;
    done_next        = done_reg;
    timeout_next     = timeout_reg;
    cfg_cycles_next  = cfg_cycles_reg;
    timeout_lim_next = timeout_lim_reg;
    energy_next      = energy_reg;
    run_cnt_next     = run_cnt_reg;
    scratch_next     = scratch_reg;
    cyc_cnt_next     = cyc_cnt_reg;
    start_next       = 1'b0;
    abort_next       = 1'b0;

    if (wr_ok) begin
      case (word_idx)
        W_CTRL: begin
          if (reg_wstrb_i[0]) begin
            irq_en_next = reg_wdata_i[2];
            // START while already running is silently ignored.
            if (reg_wdata_i[0] && (state_reg == ST_IDLE)) begin
              state_next   = ST_RUN;
              start_next   = 1'b1;
              cyc_cnt_next = '0;
            end
          end
        end
        W_STATUS: begin
          if (reg_wstrb_i[0]) begin
            if (reg_wdata_i[1]) done_next    = 1'b0;
            if (reg_wdata_i[2]) timeout_next = 1'b0;
          end
        end
        W_CFG: begin
          cfg_cycles_next = CntW'(merge_bytes(DataWidth'(cfg_cycles_reg),
                                              reg_wdata_i, wmask));
        end
        W_LIM: begin
          timeout_lim_next = CntW'(merge_bytes(DataWidth'(timeout_lim_reg),
                                               reg_wdata_i, wmask));
        end
        W_SCRATCH: begin
          scratch_next = merge_bytes(scratch_reg, reg_wdata_i, wmask);
        end
        default: ;
      endcase
    end

    if (state_reg == ST_RUN) begin
      if (done_i) begin
        // Completion takes priority over a coincident timeout.
        state_next   = ST_IDLE;
        energy_next  = energy_ext;
        done_next    = 1'b1;
        run_cnt_next = run_cnt_reg + CntW'(1);
      end else if ((timeout_lim_reg != '0) && (cyc_cnt_reg == timeout_lim_reg)) begin
        state_next   = ST_IDLE;
        timeout_next = 1'b1;
        abort_next   = 1'b1;
      end else if (cyc_cnt_reg != '1) begin
        cyc_cnt_next = cyc_cnt_reg + CntW'(1);
      end
    end

    if (soft_rst) begin
      state_next   = ST_IDLE;
      abort_next   = (state_reg == ST_RUN);
      start_next   = 1'b0;
      done_next    = 1'b0;
      timeout_next = 1'b0;
      energy_next  = '0;
      run_cnt_next = '0;
      cyc_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      irq_en_reg      <= 1'b0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      cfg_cycles_reg  <= '0;
      timeout_lim_reg <= '0;
      energy_reg      <= '0;
      run_cnt_reg     <= '0;
      scratch_reg     <= '0;
      cyc_cnt_reg     <= '0;
      start_reg       <= 1'b0;
      abort_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      irq_en_reg      <= irq_en_next;
      done_reg        <= done_next;
      timeout_reg     <= timeout_next;
      cfg_cycles_reg  <= cfg_cycles_next;
      timeout_lim_reg <= timeout_lim_next;
      energy_reg      <= energy_next;
      run_cnt_reg     <= run_cnt_next;
      scratch_reg     <= scratch_next;
      cyc_cnt_reg     <= cyc_cnt_next;
      start_reg       <= start_next;
      abort_reg       <= abort_next;
    end
  end

  // Read path: combinational, zero when the access is rejected.
  always_comb begin
    reg_rdata_o = '0;
    if (reg_valid_i && !reg_write_i && !access_err) begin
      case (word_idx)
        W_CTRL:    reg_rdata_o = DataWidth'({irq_en_reg, 2'b00});
        W_STATUS:  reg_rdata_o = DataWidth'({timeout_reg, done_reg, (state_reg == ST_RUN)});
        W_CFG:     reg_rdata_o = DataWidth'(cfg_cycles_reg);
        W_LIM:     reg_rdata_o = DataWidth'(timeout_lim_reg);
        W_ENE_LO:  reg_rdata_o = DataWidth'(energy_reg[31:0]);
        W_ENE_HI:  reg_rdata_o = DataWidth'(energy_reg[63:32]);
        W_RUN_CNT: reg_rdata_o = DataWidth'(run_cnt_reg);
        W_SCRATCH: reg_rdata_o = scratch_reg;
        default:   reg_rdata_o = '0;
      endcase
    end
  end

  assign reg_ready_o  = reg_valid_i;
  assign reg_error_o  = reg_valid_i && access_err;
  assign start_o      = start_reg;
  assign abort_o      = abort_reg;
  assign cfg_cycles_o = cfg_cycles_reg;
  assign irq_o        = irq_en_reg && (done_reg || timeout_reg);

endmodule

// File: doc/ising_core_reg_slv.md
ISING_CORE_REG_SLV -- requirements
Module: ising_core_reg_slv

Interface
REQ-001 Parameter AddrWidth, default 48, regbus address width.
REQ-002 Parameter DataWidth, default 32, regbus data width; only 32 supported.
REQ-003 Parameter EnergyW, default 32, engine energy width; legal range 1..64.
REQ-004 Parameter CntW, default 16, cycle/run counter width.
REQ-005 Parameter BaseAddr, default 0, core register window base; window is 32 bytes (8 words).
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 reg_valid_i  in  1  regbus request valid.
REQ-009 reg_write_i  in  1  1 = write, 0 = read.
REQ-010 reg_addr_i  in  AddrWidth  byte address.
REQ-011 reg_wdata_i  in  32  write data.
REQ-012 reg_wstrb_i  in  4  byte enables.
REQ-013 reg_ready_o  out  1  response ready.
REQ-014 reg_rdata_o  out  32  read data.
REQ-015 reg_error_o  out  1  access error.
REQ-016 start_o  out  1  one-cycle engine start pulse.
REQ-017 abort_o  out  1  one-cycle engine abort pulse.
REQ-018 cfg_cycles_o  out  CntW  annealing cycle count to engine.
REQ-019 done_i  in  1  one-cycle engine completion pulse.
REQ-020 energy_i  in  EnergyW  signed energy, valid when done_i=1.
REQ-021 irq_o  out  1  level interrupt.

Function
REQ-022 Register map (offset from BaseAddr): 0x00 CTRL (W): bit0 START, bit1 SOFT_RST, bit2 IRQ_EN (RW); 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 TIMEOUT (W1C); 0x08 CFG_CYCLES RW [CntW-1:0]; 0x0C TIMEOUT_LIM RW [CntW-1:0]; 0x10 ENERGY_LO RO; 0x14 ENERGY_HI RO; 0x18 RUN_CNT RO [CntW-1:0]; 0x1C SCRATCH RW 32.
REQ-023 Regbus: reg_ready_o = reg_valid_i combinationally (zero wait state); reg_rdata_o/reg_error_o combinational; state updates on the accepting edge.
REQ-024 reg_error_o=1 and no state change for: address outside window, addr[1:0]!=0, write to 0x10/0x14/0x18; reads of CTRL return IRQ_EN in bit2, bits0/1 read 0.
REQ-025 Byte strobes apply to RW fields; W1C and pulse bits act only if byte 0 strobe set; unused/reserved bits read 0.
REQ-026 FSM states IDLE, RUN. IDLE->RUN on START write with BUSY=0: start_o=1 next cycle for exactly one cycle, cycle counter cleared. START while RUN ignored, no error.
REQ-027 RUN: cycle counter increments each cycle, saturating at all-ones. RUN->IDLE on done_i: capture energy_i sign-extended to 64 bits into ENERGY_HI:LO, set DONE, RUN_CNT+1 (wraps modulo 2^CntW).
REQ-028 RUN->IDLE on timeout when TIMEOUT_LIM!=0 and counter == TIMEOUT_LIM without done_i: set TIMEOUT, abort_o=1 one cycle; energy not updated. TIMEOUT_LIM=0 disables timeout.
REQ-029 done_i and timeout same cycle: done wins, no abort.
REQ-030 done_i in IDLE ignored.
REQ-031 SOFT_RST write: FSM to IDLE, abort_o pulse if was RUN, clears DONE, TIMEOUT, ENERGY, RUN_CNT, counter; RW config regs kept. SOFT_RST with START same write: SOFT_RST wins, no start.
REQ-032 Flag set and W1C same cycle: set wins.
REQ-033 BUSY = (state==RUN); cfg_cycles_o = CFG_CYCLES register.
REQ-034 irq_o = IRQ_EN & (DONE | TIMEOUT), registered-free from flag registers.

Reset
REQ-035 On rst_ni=0 asynchronously: state IDLE, all registers 0, start_o=0, abort_o=0, irq_o=0, cfg_cycles_o=0.
REQ-036 Reset during RUN returns to IDLE with no start_o/abort_o pulse.

Verification
REQ-037 Write CFG_CYCLES=0x0100, CTRL=0x5 -> start_o one cycle, STATUS reads 0x1; done_i with energy_i=0xFFFF_FFF0 -> ENERGY_LO=0xFFFF_FFF0, ENERGY_HI=0xFFFF_FFFF, STATUS=0x2, RUN_CNT=1, irq_o=1; write STATUS=0x2 -> irq_o=0.
REQ-038 TIMEOUT_LIM=4, START, no done_i -> abort_o after counter reaches 4, STATUS=0x4, ENERGY unchanged; repeat with done_i and timeout coincident -> STATUS=0x2, no abort_o.
REQ-039 Read 0x20 offset, read 0x02, write 0x10 -> reg_error_o=1, registers unchanged; SCRATCH write 0xDEADBEEF with wstrb=0x3 -> reads 0x0000BEEF.
REQ-040 START twice during RUN -> single start_o; SOFT_RST mid-RUN -> abort_o, STATUS=0, RUN_CNT=0, CFG_CYCLES retained.
REQ-041 2^CntW completed runs -> RUN_CNT wraps to 0; rst_ni asserted mid-RUN -> all outputs 0 immediately, no pulses.
